// File: rtl/pc_stack.sv
// Program counter with an integrated hardware return-address stack (call/ret).
// Optional build macro PC_STACK_WRAP_EN makes the stack circular on overflow.
module pc_stack #(
   parameter int               WIDTH       = 16,
   parameter int               DEPTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in,
   input  logic                       load,
   input  logic                       inc,
   input  logic                       call,
   input  logic                       ret,
   output logic [WIDTH-1:0]           out,
   output logic [WIDTH-1:0]           top,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = $clog2(DEPTH + 1);
   localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

   function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
      return v + WIDTH'(1);
   endfunction

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [DW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push;
   logic [AW-1:0]    top_idx;
   logic [WIDTH-1:0] pc_inc;
   logic             full_w, empty_w;

   logic [WIDTH-1:0] stack_mem [DEPTH];

   // wptr is the next write slot; the newest entry always sits one below it,
   // which keeps the same addressing valid for the circular build.
   assign top_idx = wptr_q - AW'(1);
   assign pc_inc  = wrap_inc(pc_q);
   assign full_w  = (cnt_q == FULL_CNT);
   assign empty_w = (cnt_q == '0);

   always_comb begin
      pc_d   = pc_q;
      cnt_d  = cnt_q;
      wptr_d = wptr_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      push   = 1'b0;
      if (call) begin
         pc_d = in;
         if (!full_w) begin
            push   = 1'b1;
            cnt_d  = cnt_q + DW'(1);
            wptr_d = wptr_q + AW'(1);
         end else begin
            ovf_d = 1'b1;
`ifdef PC_STACK_WRAP_EN
            // Overwrite the oldest slot; depth stays pinned at DEPTH.
            push   = 1'b1;
            wptr_d = wptr_q + AW'(1);
`endif
         end
      end else if (ret) begin
         if (!empty_w) begin
            pc_d   = stack_mem[top_idx];
            cnt_d  = cnt_q - DW'(1);
            wptr_d = top_idx;
         end else begin
            unf_d = 1'b1;
         end
      end else if (load) begin
         pc_d = in;
      end else if (inc) begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_q   <= RESET_VALUE;
         cnt_q  <= '0;
         wptr_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         cnt_q  <= cnt_d;
         wptr_q <= wptr_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   // Stack storage carries no reset; a low reset only blocks the write.
   always_ff @(posedge clock) begin
      if (reset && push) begin
         stack_mem[wptr_q] <= pc_inc;
      end
   end

   assign out       = pc_q;
   assign depth     = cnt_q;
   assign full      = full_w;
   assign empty     = empty_w;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign top       = empty_w ? '0 : stack_mem[top_idx];

endmodule
